// File: rtl/instr_vector_player.sv
// instr_vector_player
//   Replays a loaded instruction vector table into a pipelined datapath and
//   checks the datapath's result observations, in order, against per-vector
//   expected values. A run stops at an all-zero sentinel entry or at the end
//   of the table. The engine then waits a bounded number of cycles for any
//   outstanding observations before it reports done.
//
// Optional build macro: INSTR_PLAYER_FAIL_LOG_EN
//   When defined, o_fail_idx/o_fail_data record the compare index and the
//   observed data of the first data mismatch in a run. When undefined, both
//   ports are driven with 0.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        pulse; begins a run from IDLE or DONE
//   load_we      table write strobe, honoured in IDLE/DONE only
//   load_addr    table write index
//   load_instr   instruction word to store
//   load_exp     expected observation for that entry
//   stall        datapath stall; holds the current issue
//   obs_valid    datapath result valid
//   obs_data     datapath result
//   o_instr      instruction driven to the datapath (0 = NOP)
//   o_valid      o_instr is a live vector
//   o_vectnum    number of vectors issued
//   o_errors     saturating mismatch count
//   o_busy       run or drain in progress
//   o_done       run finished
//   o_timeout    drain ended by timeout
//   o_fail_idx   first failing compare index (optional)
//   o_fail_data  observed data at first failure (optional)
module instr_vector_player #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_exp,
  input  logic              stall,
  input  logic              obs_valid,
  input  logic [DATA_W-1:0] obs_data,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_valid,
  output logic [ADDR_W:0]   o_vectnum,
  output logic [ERR_W-1:0]  o_errors,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [ADDR_W-1:0] o_fail_idx,
  output logic [DATA_W-1:0] o_fail_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int CNT_W = ADDR_W + 1;
  localparam int DRN_W = $clog2(TIMEOUT) + 1;
  localparam int SUM_W = ((ERR_W > CNT_W) ? ERR_W : CNT_W) + 2;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] exp_mem   [DEPTH];

  state_t            state, state_next;
  logic [CNT_W-1:0]  issue_ptr, issue_next;
  logic [CNT_W-1:0]  cmp_ptr, cmp_next;
  logic [DRN_W-1:0]  drain_cnt, drain_next;
  logic [ERR_W-1:0]  err_cnt, err_next;
  logic [DATA_W-1:0] instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic              timeout_reg, timeout_next;

  logic              idle_or_done;
  logic              run_start;
  logic              active;
  logic              mismatch;
  logic              err_inc;
  logic [CNT_W-1:0]  shortfall;
  logic [SUM_W-1:0]  err_sum;
  logic [DATA_W-1:0] cur_instr;
  logic [DATA_W-1:0] cur_exp;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign run_start    = idle_or_done && start;
  assign active       = (state == S_RUN) || (state == S_DRAIN);
  assign cur_instr    = instr_mem[issue_ptr[ADDR_W-1:0]];
  assign cur_exp      = exp_mem[cmp_ptr[ADDR_W-1:0]];

  // Table storage: not cleared by reset; a write coinciding with start is dropped.
  always_ff @(posedge clk) begin
    if (!reset && idle_or_done && load_we && !start) begin
      instr_mem[load_addr] <= load_instr;
      exp_mem[load_addr]   <= load_exp;
    end
  end

  // In-order compare, independent of stall. With nothing outstanding an
  // observation is itself an error and the compare pointer stays put.
  always_comb begin
    cmp_next = cmp_ptr;
    err_inc  = 1'b0;
    mismatch = 1'b0;
    if (run_start) begin
      cmp_next = '0;
    end else if (active && obs_valid) begin
      if (cmp_ptr == issue_ptr) begin
        err_inc = 1'b1;
      end else begin
        mismatch = (obs_data != cur_exp);
        err_inc  = mismatch;
        cmp_next = cmp_ptr + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next   = state;
    issue_next   = issue_ptr;
    drain_next   = drain_cnt;
    instr_next   = instr_reg;
    valid_next   = valid_reg;
    timeout_next = timeout_reg;
    shortfall    = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next   = S_RUN;
          issue_next   = '0;
          drain_next   = '0;
          instr_next   = '0;
          valid_next   = 1'b0;
          timeout_next = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (issue_ptr == CNT_W'(DEPTH) || cur_instr == '0) begin
            instr_next = '0;
            valid_next = 1'b0;
            state_next = S_DRAIN;
          end else begin
            instr_next = cur_instr;
            valid_next = 1'b1;
            issue_next = issue_ptr + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        drain_next = drain_cnt + DRN_W'(1);
        // Exit test uses the post-compare pointer so a final observation
        // arriving in this cycle both counts and completes the drain.
        if (cmp_next == issue_ptr) begin
          state_next = S_DONE;
        end else if (drain_cnt == DRN_W'(TIMEOUT - 1)) begin
          state_next   = S_DONE;
          timeout_next = 1'b1;
          shortfall    = issue_ptr - cmp_next;
        end
      end
      default: state_next = S_IDLE;
    endcase

    err_sum = SUM_W'(err_cnt) + SUM_W'(err_inc) + SUM_W'(shortfall);
    if (run_start) begin
      err_next = '0;
    end else if (|err_sum[SUM_W-1:ERR_W]) begin
      err_next = '1;
    end else begin
      err_next = err_sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      issue_ptr   <= '0;
      cmp_ptr     <= '0;
      drain_cnt   <= '0;
      err_cnt     <= '0;
      instr_reg   <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state       <= state_next;
      issue_ptr   <= issue_next;
      cmp_ptr     <= cmp_next;
      drain_cnt   <= drain_next;
      err_cnt     <= err_next;
      instr_reg   <= instr_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_instr   = instr_reg;
  assign o_valid   = valid_reg;
  assign o_vectnum = issue_ptr;
  assign o_errors  = err_cnt;
  assign o_busy    = active;
  assign o_done    = (state == S_DONE);
  assign o_timeout = timeout_reg;

`ifdef INSTR_PLAYER_FAIL_LOG_EN
  logic              fail_seen;
  logic [ADDR_W-1:0] fail_idx_reg;
  logic [DATA_W-1:0] fail_data_reg;

  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      fail_seen     <= 1'b0;
      fail_idx_reg  <= '0;
      fail_data_reg <= '0;
    end else if (mismatch && !fail_seen) begin
      fail_seen     <= 1'b1;
      fail_idx_reg  <= cmp_ptr[ADDR_W-1:0];
      fail_data_reg <= obs_data;
    end
  end

  assign o_fail_idx  = fail_idx_reg;
  assign o_fail_data = fail_data_reg;
`else
  assign o_fail_idx  = '0;
  assign o_fail_data = '0;
`endif

endmodule
